mem_arbiter: RTL

// - Unified single-port word memory shared by the instruction and data ports of the datapath.
// - Replaces the split imem/dmem pair in top with one parametrised block.
// - Adds valid/ready request handshakes, configurable read latency, byte-enable writes and

---
 rtl/mem_arbiter.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port word memory shared by an instruction fetch port and a data port.
// Valid/ready requests, round-robin arbitration, byte-enable writes, fixed read latency.
module mem_arbiter #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned DEPTH   = 1024,
    parameter int unsigned LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_req_valid,
    output logic                i_req_ready,
    input  logic [XLEN-1:0]     i_addr,
    output logic                i_rsp_valid,
    output logic [XLEN-1:0]     i_rdata,
    input  logic                d_req_valid,
    output logic                d_req_ready,
    input  logic [XLEN-1:0]     d_addr,
    input  logic                d_we,
    input  logic [XLEN/8-1:0]   d_be,
    input  logic [XLEN-1:0]     d_wdata,
    output logic                d_rsp_valid,
    output logic [XLEN-1:0]     d_rdata
);

    localparam int unsigned BE_W = XLEN / 8;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CW   = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_nxt;

    logic            can_accept;
    logic            grant_d;
    logic            accept_i;
    logic            accept_d;
    logic            accept;
    logic            last_grant_d;

    logic            pend_d;
    logic [XLEN-1:0] pend_data;
    logic            rsp_nxt;
    logic            rsp_to_d;
    logic [XLEN-1:0] rsp_data;
    logic [XLEN-1:0] acc_data;

    logic [AW-1:0]   i_idx;
    logic [AW-1:0]   d_idx;
    logic [AW-1:0]   acc_idx;
    logic            addr_unused;

    logic [XLEN-1:0] mem [DEPTH];

    // Word index: byte offset and bits above the array size are dropped (wraps).
    assign i_idx       = i_addr[AW+1:2];
    assign d_idx       = d_addr[AW+1:2];
    assign addr_unused = ^{i_addr[XLEN-1:AW+2], i_addr[1:0], d_addr[XLEN-1:AW+2], d_addr[1:0]};

    assign accept_i = i_req_valid && i_req_ready;
    assign accept_d = d_req_valid && d_req_ready;
    assign accept   = accept_i || accept_d;
    assign acc_idx  = accept_d ? d_idx : i_idx;
    assign acc_data = (accept_d && d_we) ? '0 : mem[acc_idx];

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next state: WAIT with cnt==0 is the response cycle, which may also take a new request.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CW'(LATENCY - 1);
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - CW'(1);
                end else if (accept) begin
                    cnt_nxt = CW'(LATENCY - 1);
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Ready/grant: D wins a tie unless it was the last port granted.
    always_comb begin
        can_accept  = 1'b0;
        grant_d     = 1'b0;
        i_req_ready = 1'b0;
        d_req_ready = 1'b0;
        if (reset) begin
            can_accept  = (state == IDLE) || (cnt == '0);
            grant_d     = d_req_valid && (!i_req_valid || !last_grant_d);
            d_req_ready = can_accept && grant_d;
            i_req_ready = can_accept && i_req_valid && !grant_d;
        end
    end

    assign rsp_nxt  = (state_nxt == WAIT) && (cnt_nxt == '0);
    assign rsp_to_d = accept ? accept_d : pend_d;
    assign rsp_data = accept ? acc_data : pend_data;

    // Pending transaction bookkeeping and registered response outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            i_rsp_valid  <= 1'b0;
            d_rsp_valid  <= 1'b0;
            i_rdata      <= '0;
            d_rdata      <= '0;
            last_grant_d <= 1'b0;
            pend_d       <= 1'b0;
            pend_data    <= '0;
        end else begin
            i_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
            if (accept) begin
                last_grant_d <= accept_d;
                pend_d       <= accept_d;
                pend_data    <= acc_data;
            end
            if (rsp_nxt) begin
                if (rsp_to_d) begin
                    d_rsp_valid <= 1'b1;
                    d_rdata     <= rsp_data;
                end else begin
                    i_rsp_valid <= 1'b1;
                    i_rdata     <= rsp_data;
                end
            end
        end
    end

    // Storage is never reset; byte lanes written at the accept edge.
    always_ff @(posedge clk) begin
        if (accept_d && d_we) begin
            for (int k = 0; k < int'(BE_W); k++) begin
                if (d_be[k]) begin
                    mem[d_idx][8*k +: 8] <= d_wdata[8*k +: 8];
                end
            end
        end
    end

endmodule
